dmem_responder: RTL and testbench
=================================

# dmem_responder

Byte-wide data-memory responder for the S-slot load/store path. It accepts one load or store request at a time from the pipeline over a valid/ready handshake. It inserts a programmable number of wait states, then returns a zero-extended 32-bit read word (or a store acknowledge) over a valid/ready response channel. It replaces the single-cycle data memory behind the EX/MEM stage, and its `busy` output feeds the hazard unit so the pipeline stalls while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, default 8: byte-address width of the array; depth is 2^ADDR_W bytes.
- `WAIT_CYCLES`, default 2: wait states inserted before each access. Legal range is 0..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the responder can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address (ALU/S-type result).
- `req_wdata` in 8: store byte.
- `rsp_valid` out 1: a response is presented.
- `rsp_ready` in 1: the pipeline consumes the response.
- `rsp_rdata` out 32: load data, zero-extended from 8 bits; 0 for stores.
- `rsp_err` out 1: the request address was out of range.
- `busy` out 1: a request is outstanding (the state is not IDLE).

## Operation
- FSM states: IDLE, WAIT, RESP. Counter `cnt` is 4 bits.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: capture `req_write`, `req_addr`, `req_wdata`.
  - If `WAIT_CYCLES`=0, perform the access at this edge and go to RESP.
  - Otherwise load `cnt`=`WAIT_CYCLES` and go to WAIT.
- **WAIT**
  - `req_ready`=0.
  - If `cnt`>1, decrement `cnt` and stay in WAIT.
  - If `cnt`==1, perform the access at this edge and go to RESP.
- **Access** (single edge)
  - In range means `req_addr[31:ADDR_W]`==0.
  - In-range store: write `mem[addr]` ← wdata; `rsp_rdata`←0; `rsp_err`←0.
  - In-range load: `rsp_rdata` ← {24'b0, `mem[addr]`}; `rsp_err`←0.
  - Out of range: no array write; `rsp_rdata`←0; `rsp_err`←1.
- **RESP**
  - `rsp_valid`=1.
  - `rsp_rdata` and `rsp_err` are held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE. `req_valid` is ignored while in RESP.
- `busy` = (state != IDLE). This is a registered decode, never combinational from `req_valid`.
- Reset, asynchronous:
  - State goes to IDLE and `cnt`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0; `req_ready`=1 after reset releases.
  - All array bytes are cleared to 0.
  - A request in flight is abandoned. A store not yet committed is never written.

## Timing
- A request is accepted at the edge E where `req_valid`&&`req_ready`.
- The access happens at edge E+`WAIT_CYCLES`. `rsp_valid` rises after that edge.
- Load-to-use latency is therefore `WAIT_CYCLES` edges; with `WAIT_CYCLES`=0 the response is visible in the cycle after E.
- A response consumed at edge F returns the FSM to IDLE at F. The next request can be accepted at F+1 at the earliest.
- Maximum throughput is one request per `WAIT_CYCLES`+2 cycles.
- Store-then-load to the same address returns the new byte, because the store commits before its response.
- `rsp_ready` held high on entry to RESP gives a one-cycle `rsp_valid` pulse.
- Backpressure holds RESP indefinitely, with no data change.
- `req_addr`, `req_wdata` and `req_write` need only be valid at the accept edge.

## Test plan
- **Reset defaults:** assert `reset` mid-cycle → `rsp_valid`=0, `busy`=0, `rsp_rdata`=0 immediately; after release `req_ready`=1; a load from 0x05 returns 0x00000000.
- **Store then load:** `WAIT_CYCLES`=2; store 0xA5 to 0x10, then load 0x10 → `rsp_valid` 2 edges after each accept; load `rsp_rdata`=0x000000A5, `rsp_err`=0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles after a load of a byte holding 0x3C → `rsp_valid` stays 1, `rsp_rdata` stays 0x0000003C, `req_ready`=0, and a `req_valid` pulse meanwhile is not accepted.
- **Out of range:** `ADDR_W`=8; store 0xFF to 0x100 → `rsp_err`=1; a subsequent load of 0x00 returns 0x00000000 (no aliasing).
- **Reset mid-WAIT:** store 0x77 to 0x20, assert `reset` one cycle after accept → the FSM is in IDLE; a later load of 0x20 returns 0x00000000.
- **Zero wait:** `WAIT_CYCLES`=0; back-to-back loads with `rsp_ready`=1 → `rsp_valid` the cycle after each accept; accepts occur every 2 cycles; `busy` is high exactly during RESP.

Source files
------------

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Byte-wide data memory with programmable wait states and
//            valid/ready request and response channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int c_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q;
  logic [7:0]  wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        busy_q;
  logic [7:0]  mem_q [c_DEPTH];

  logic              w_access;
  logic              w_acc_write;
  logic [31:0]       w_acc_addr;
  logic [7:0]        w_acc_wdata;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_acc_idx;

  // A zero-wait access happens at the accept edge, so it must use the live inputs.
  assign w_acc_write = (state_q == S_IDLE) ? req_write : write_q;
  assign w_acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign w_acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign w_in_range  = (w_acc_addr >> ADDR_W) == 32'd0;
  assign w_acc_idx   = w_acc_addr[ADDR_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_access  = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_access = 1'b1;
            state_d  = S_RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          w_access = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (w_access) begin
      if (!w_in_range) begin
        rdata_d = 32'd0;
        err_d   = 1'b1;
      end else if (w_acc_write) begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end else begin
        rdata_d = {24'd0, mem_q[w_acc_idx]};
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
      if (state_q == S_IDLE && req_valid) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) mem_q[i] <= 8'd0;
    end else if (w_access && w_acc_write && w_in_range) begin
      mem_q[w_acc_idx] <= w_acc_wdata;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Scoreboard bench for dmem_responder (WAIT_CYCLES=2 and 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [7:0]  d;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  exp_t q2[$];
  exp_t q0[$];

  // DUT with two wait states
  logic        rv2 = 1'b0, rw2 = 1'b0, rr2 = 1'b1;
  logic [31:0] ra2 = 32'd0;
  logic [7:0]  wd2 = 8'd0;
  logic        rqr2, rsv2, re2, b2;
  logic [31:0] rd2;

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid(rv2), .req_ready(rqr2), .req_write(rw2),
    .req_addr(ra2), .req_wdata(wd2),
    .rsp_valid(rsv2), .rsp_ready(rr2), .rsp_rdata(rd2), .rsp_err(re2),
    .busy(b2)
  );

  // DUT with zero wait states
  logic        rv0 = 1'b0, rw0 = 1'b0, rr0 = 1'b1;
  logic [31:0] ra0 = 32'd0;
  logic [7:0]  wd0 = 8'd0;
  logic        rqr0, rsv0, re0, b0;
  logic [31:0] rd0;

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv0), .req_ready(rqr0), .req_write(rw0),
    .req_addr(ra0), .req_wdata(wd0),
    .rsp_valid(rsv0), .rsp_ready(rr0), .rsp_rdata(rd0), .rsp_err(re0),
    .busy(b0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsv2 === 1'b1 && rr2 === 1'b1) begin
      exp_t e;
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL mon2_unexpected: got a response, expected none");
      end else begin
        e = q2.pop_front();
        chk("rsp2_rdata", rd2, e.rdata);
        chk("rsp2_err", {31'd0, re2}, {31'd0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && rsv0 === 1'b1 && rr0 === 1'b1) begin
      exp_t e;
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL mon0_unexpected: got a response, expected none");
      end else begin
        e = q0.pop_front();
        chk("rsp0_rdata", rd0, e.rdata);
        chk("rsp0_err", {31'd0, re0}, {31'd0, e.err});
      end
    end
  end

  // Issue one request to the two-wait DUT, push its expectation and measure latency.
  task automatic req2(input logic w, input logic [31:0] a, input logic [7:0] d,
                      input logic [31:0] er, input logic ee);
    int k;
    @(negedge clk);
    rv2 = 1'b1; rw2 = w; ra2 = a; wd2 = d;
    k = 0;
    while (rqr2 !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("req2_ready_timeout", {31'd0, rqr2}, 32'd1);
    @(posedge clk);
    q2.push_back('{er, ee});
    #1;
    rv2 = 1'b0; rw2 = ~w; ra2 = 32'hFFFF_FFFF; wd2 = 8'h00;
    k = 0;
    @(negedge clk);
    while (rsv2 !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("lat2", k, 32'd2);
  endtask

  vec_t v0[5] = '{
    '{1'b1, 32'h0000_0003, 8'h5A, 32'h0000_0000, 1'b0},
    '{1'b0, 32'h0000_0003, 8'h00, 32'h0000_005A, 1'b0},
    '{1'b0, 32'h0000_0004, 8'h00, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0000_01FF, 8'hEE, 32'h0000_0000, 1'b1},
    '{1'b0, 32'h0000_00FF, 8'h00, 32'h0000_0000, 1'b0}
  };

  initial begin
    // Reset asserted mid-cycle must clear outputs immediately.
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'd0, rsv2}, 32'd0);
    chk("rst_busy", {31'd0, b2}, 32'd0);
    chk("rst_rdata", rd2, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, rqr2}, 32'd1);

    req2(1'b0, 32'h05, 8'h00, 32'h0, 1'b0);
    req2(1'b1, 32'h10, 8'hA5, 32'h0, 1'b0);
    req2(1'b0, 32'h10, 8'h00, 32'hA5, 1'b0);
    req2(1'b1, 32'h11, 8'h3C, 32'h0, 1'b0);

    // Backpressure: response held while a stray request is offered.
    @(posedge clk); #1 rr2 = 1'b0;
    req2(1'b0, 32'h11, 8'h00, 32'h3C, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin rv2 = 1'b1; rw2 = 1'b1; ra2 = 32'h11; wd2 = 8'h99; end
      if (i == 3) rv2 = 1'b0;
      chk("bp_rsp_valid", {31'd0, rsv2}, 32'd1);
      chk("bp_rdata", rd2, 32'h3C);
      chk("bp_req_ready", {31'd0, rqr2}, 32'd0);
    end
    @(posedge clk); #1 rr2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_busy", {31'd0, b2}, 32'd0);
    req2(1'b0, 32'h11, 8'h00, 32'h3C, 1'b0);

    // Out-of-range store must not alias onto byte 0.
    req2(1'b1, 32'h100, 8'hFF, 32'h0, 1'b1);
    req2(1'b0, 32'h00, 8'h00, 32'h0, 1'b0);

    // Reset one cycle into the wait window abandons the store.
    @(negedge clk);
    rv2 = 1'b1; rw2 = 1'b1; ra2 = 32'h20; wd2 = 8'h77;
    chk("rw_req_ready", {31'd0, rqr2}, 32'd1);
    @(posedge clk); #1 rv2 = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("rw_busy", {31'd0, b2}, 32'd0);
    chk("rw_req_ready_idle", {31'd0, rqr2}, 32'd1);
    chk("rw_rsp_valid", {31'd0, rsv2}, 32'd0);
    q2.delete();
    @(negedge clk);
    reset = 1'b0;
    req2(1'b0, 32'h20, 8'h00, 32'h0, 1'b0);

    // Zero-wait DUT: back-to-back requests with rsp_ready held high.
    begin
      int idx = 0;
      int last = 0;
      bit pend = 1'b0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        chk("z_busy_eq_valid", {31'd0, b0}, {31'd0, rsv0});
        if (pend) begin
          chk("z_lat", {31'd0, rsv0}, 32'd1);
          pend = 1'b0;
        end
        if (rqr0 === 1'b1 && idx < 5) begin
          rv0 = 1'b1; rw0 = v0[idx].w; ra0 = v0[idx].a; wd0 = v0[idx].d;
          q0.push_back('{v0[idx].er, v0[idx].ee});
          if (idx > 0) chk("z_spacing", cyc + 1 - last, 32'd2);
          last = cyc + 1;
          pend = 1'b1;
          idx++;
        end else if (rqr0 === 1'b1) begin
          rv0 = 1'b0;
        end
      end
      chk("z_all_issued", idx, 32'd5);
    end

    repeat (3) @(negedge clk);
    chk("q2_drained", q2.size(), 32'd0);
    chk("q0_drained", q0.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
